// File: rtl/ru_feeder_pkg.sv
// Shared types and CRC helper for the remote-update page feeder.
// CRC logic is only instantiated when RU_FEEDER_CRC_EN is defined.
package ru_feeder_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCalc,
        StWaitData,
        StReq,
        StStream,
        StWaitDone,
        StError
    } state_e;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // CRC-16/CCITT, MSB-first, one byte per call.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/ru_feeder_skid.sv
// Two-entry byte skid buffer between a 1-cycle-latency FIFO read port and a valid/ready sink.
// Reads are only issued while buffered plus in-flight bytes stay below two.
module ru_feeder_skid (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       allow,
    output logic       rd_en,
    input  logic [7:0] rd_data,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready
);

    logic [1:0][7:0] buf_q, buf_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            inflight_q;
    logic            pop;

    assign rd_en     = allow && !flush && ((cnt_q + 2'(inflight_q)) < 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = buf_q[0];
    assign pop       = out_valid && out_ready;

    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (pop) begin
            buf_d[0] = buf_q[1];
            cnt_d    = cnt_q - 2'd1;
        end
        // Data for a read issued last cycle lands behind whatever is still queued.
        if (inflight_q) begin
            buf_d[cnt_d[0]] = rd_data;
            cnt_d           = cnt_d + 2'd1;
        end
        if (flush) begin
            cnt_d = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q      <= '0;
            cnt_q      <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            inflight_q <= rd_en;
        end
    end

endmodule

// File: rtl/remote_update_page_feeder.sv
// Splits a bitstream job into page-aligned flash program transfers fed from the update FIFO.
// Define RU_FEEDER_CRC_EN to add a running CRC-16/CCITT over accepted bytes on crc_out.
module remote_update_page_feeder
    import ru_feeder_pkg::*;
#(
    parameter int unsigned PAGE_BYTES = 256,
    parameter int unsigned ADDR_W     = 24,
    parameter int unsigned LEN_W      = 24,
    parameter int unsigned LVL_W      = 12,
    parameter int unsigned DONE_TMO   = 2000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  total_len,
    input  logic              abort,
    output logic              busy,
    output logic              job_done,
    output logic              job_err,
    output logic              fifo_rd_en,
    input  logic [7:0]        fifo_rd_data,
    input  logic              fifo_rd_empty,
    input  logic [LVL_W:0]    fifo_rd_level,
    output logic              pp_req,
    output logic [ADDR_W-1:0] pp_addr,
    output logic [9:0]        pp_len,
    input  logic              pp_ack,
    output logic              pp_valid,
    output logic [7:0]        pp_data,
    input  logic              pp_ready,
    input  logic              pp_done,
    output logic [15:0]       crc_out
);

    localparam int unsigned OffW    = $clog2(PAGE_BYTES);
    localparam int unsigned CntW    = $clog2(PAGE_BYTES + 1);
    localparam int unsigned TmoW    = $clog2(DONE_TMO + 1);
    localparam int unsigned LvlBits = LVL_W + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [CntW-1:0]   chunk_q, chunk_d;
    logic [CntW-1:0]   issued_q, issued_d;
    logic [CntW-1:0]   acc_q, acc_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic              job_done_q, job_done_d;
    logic              job_err_q, job_err_d;
    logic [CntW-1:0]   room;
    logic              accept;
    logic              allow;

    assign room   = CntW'(PAGE_BYTES) - CntW'(addr_q[OffW-1:0]);
    assign accept = pp_valid && pp_ready;
    assign allow  = (state_q == StStream) && (issued_q != chunk_q) && !fifo_rd_empty;

    ru_feeder_skid u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort),
        .allow     (allow),
        .rd_en     (fifo_rd_en),
        .rd_data   (fifo_rd_data),
        .out_valid (pp_valid),
        .out_data  (pp_data),
        .out_ready (pp_ready)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        chunk_d    = chunk_q;
        issued_d   = issued_q;
        acc_d      = acc_q;
        tmo_d      = '0;
        job_done_d = 1'b0;
        job_err_d  = job_err_q;
        if (fifo_rd_en) issued_d = issued_q + 1'b1;
        if (accept)     acc_d    = acc_q + 1'b1;

        unique case (state_q)
            // ERROR behaves like IDLE for a new start; only busy differs.
            StIdle, StError: begin
                if (start && !abort) begin
                    job_err_d = 1'b0;
                    addr_d    = base_addr;
                    rem_d     = total_len;
                    if (total_len == '0) begin
                        job_done_d = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                chunk_d  = (rem_q < LEN_W'(room)) ? CntW'(rem_q) : room;
                issued_d = '0;
                acc_d    = '0;
                state_d  = StWaitData;
            end
            StWaitData: begin
                if (fifo_rd_level >= LvlBits'(chunk_q)) state_d = StReq;
            end
            StReq: begin
                if (pp_ack) state_d = StStream;
            end
            StStream: begin
                if (accept && (acc_q == chunk_q - 1'b1)) begin
                    addr_d  = addr_q + ADDR_W'(chunk_q);
                    rem_d   = rem_q - LEN_W'(chunk_q);
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                tmo_d = tmo_q + 1'b1;
                if (pp_done) begin
                    tmo_d = '0;
                    if (rem_q == '0) begin
                        job_done_d = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        state_d = StCalc;
                    end
                end else if (tmo_q == TmoW'(DONE_TMO - 1)) begin
                    job_err_d = 1'b1;
                    state_d   = StError;
                end
            end
            default: state_d = StIdle;
        endcase

        if (abort) begin
            state_d    = StIdle;
            job_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            rem_q      <= '0;
            chunk_q    <= '0;
            issued_q   <= '0;
            acc_q      <= '0;
            tmo_q      <= '0;
            job_done_q <= 1'b0;
            job_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            chunk_q    <= chunk_d;
            issued_q   <= issued_d;
            acc_q      <= acc_d;
            tmo_q      <= tmo_d;
            job_done_q <= job_done_d;
            job_err_q  <= job_err_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign job_done = job_done_q;
    assign job_err  = job_err_q;
    assign pp_req   = (state_q == StReq);
    assign pp_addr  = addr_q;
    assign pp_len   = 10'(chunk_q);

`ifdef RU_FEEDER_CRC_EN
    logic [15:0] crc_q;
    logic        start_ok;

    assign start_ok = start && !abort && ((state_q == StIdle) || (state_q == StError));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC16_INIT;
        end else if (start_ok) begin
            crc_q <= CRC16_INIT;
        end else if (accept) begin
            crc_q <= crc16_byte(crc_q, pp_data);
        end
    end

    assign crc_out = crc_q;
`else
    assign crc_out = 16'h0000;
`endif

endmodule
